wfifo_frame_packer: RTL and testbench
=====================================

// Module: wfifo_frame_packer
// PURPOSE
//  Write-side front end for the DDR write FIFO, in the wfifo_wr_clk (video-in) domain. Packs IN_W-bit pixels into
//  OUT_W-bit FIFO words and adds a partial-word flush at frame end. Generates a programmable per-frame FIFO reset
//  from the vsync active edge, followed by a guard window. Adds frame and word counters and a sticky overflow flag.
// PARAMETERS
//  IN_W          32   pixel width; OUT_W/IN_W = RATIO, power of two, >=1
//  OUT_W         256  FIFO write word width
//  VS_POL        1    vsync active level (1 = high)
//  RST_CYCLES    14   fifo_rst pulse length, cycles (>=1)
//  GUARD_CYCLES  16   post-reset cycles before pixels are accepted (>=1)
//  PAD_VAL       0    IN_W-bit fill value for unused lanes of a flushed word
// PORTS
//  wfifo_wr_clk  in   1      clock
//  rstn          in   1      synchronous active-low reset
//  vs_in         in   1      vsync, asynchronous to wfifo_wr_clk
//  pix_valid     in   1      pixel strobe
//  pix_data      in   IN_W   pixel
//  fifo_full     in   1      write-FIFO full
//  fifo_rst      out  1      FIFO reset, both FIFO sides
//  fifo_wr_en    out  1      FIFO write strobe
//  fifo_wr_data  out  OUT_W  FIFO write word
//  frame_start   out  1      1-cycle pulse when pixel acceptance begins
//  frame_cnt     out  16     frames started, wraps at 65535->0
//  frame_words   out  16     words written in the last completed frame
//  overflow      out  1      sticky: a word was dropped on fifo_full
// BEHAVIOUR
//  Reset (rstn=0 at a clock edge):
//   - fifo_rst=1; all other outputs 0; lane count 0; state IDLE.
//   - rstn low mid-frame discards the partial word; no write is made.
//  Vsync path:
//   - vs_act = (vs_in==VS_POL). It passes a 2-flop synchroniser, then a rising-edge detect.
//   - vs_edge is a 1-cycle pulse. It is registered 3 clocks after vs_act first samples high.
//  FSM states: IDLE, FLUSH, RST, GUARD, RUN.
//   - IDLE: fifo_rst=0; pixels ignored. On vs_edge -> RST.
//   - RST: fifo_rst=1 for exactly RST_CYCLES cycles -> GUARD.
//   - GUARD: fifo_rst=0; pixels ignored; lasts GUARD_CYCLES cycles.
//     On exit: frame_start pulses, frame_cnt+1, word count cleared -> RUN.
//   - RUN: pack pixels. On vs_edge: if lane count != 0 -> FLUSH, else latch frame_words -> RST.
//   - FLUSH: exactly 1 cycle. Writes the partial word, unused lanes = PAD_VAL.
//     frame_words latched including this word -> RST.
//   - vs_edge in RST, GUARD or FLUSH is ignored; the running timers are not restarted.
//  Packing (RUN only):
//   - Pixel k of a word goes to bits [k*IN_W +: IN_W]; k=0 is the first pixel after frame start.
//   - On the RATIO-th pixel the word is complete. fifo_wr_en=1 and fifo_wr_data are registered on the next edge
//     (1-cycle latency); lane count returns to 0.
//   - If RATIO=1, every valid pixel produces a write.
//   - pix_valid on the cycle vs_edge is seen in RUN: the pixel is packed before the flush decision.
//  Overflow:
//   - fifo_full is sampled in the cycle the write would issue. If high: no write, word dropped, overflow<=1.
//   - overflow clears only on rstn. The word counter does not increment for a dropped word.
//  Counters:
//   - Word counter saturates at 65535.
//   - frame_words holds its value until the next frame end.
// STRUCTURE
//  Shared package wfifo_pkg:
//   - FSM state enum (3-bit).
//   - clog2-based counter-width function for RATIO, RST_CYCLES and GUARD_CYCLES.
//  One sub-module, vs_edge_sync: 2-flop synchroniser plus polarity select plus rising-edge pulse.
//  Top level holds the FSM, the shared reset/guard timer, the lane shifter and the counters.
// TESTING
//  1 Reset: rstn=0 for 4 cycles -> fifo_rst=1, fifo_wr_en=0, frame_cnt=0, overflow=0. After release, fifo_rst=0
//    and no writes occur while pixels stream with no vsync.
//  2 vs_in rises (defaults) -> fifo_rst=1 for exactly 14 cycles, then 16 guard cycles, then one frame_start pulse;
//    frame_cnt=1.
//  3 IN_W=32, OUT_W=256; 16 back-to-back pixels 0..15 -> two writes, each one cycle after its 8th pixel.
//    Word0 = {32'd7,...,32'd1,32'd0}; Word1 = {32'd15,...,32'd8}.
//  4 Pixels A,B,C, then vsync -> one FLUSH write {160'h0,C,B,A}, then fifo_rst pulse; frame_words=1.
//  5 fifo_full=1 during the 8th pixel's write cycle -> no fifo_wr_en, overflow=1. overflow stays 1 across the next
//    frame until rstn.
//  6 Second vsync edge 5 cycles into RST -> pulse still exactly 14 cycles. rstn=0 in RUN with 5 lanes filled ->
//    no write, fifo_rst=1.

Source files
------------

// File: rtl/wfifo_pkg.sv
// Shared types and sizing helpers for the DDR write-FIFO front end.
package wfifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_RST   = 3'd2,
        ST_GUARD = 3'd3,
        ST_RUN   = 3'd4
    } fsm_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wfifo_frame_packer_vs_edge_sync.sv
// Vsync polarity select, 2-flop synchroniser and registered rising-edge pulse.
module vs_edge_sync #(
    parameter bit VS_POL = 1'b1
) (
    input  logic wfifo_wr_clk,
    input  logic rstn,
    input  logic vs_in,
    output logic vs_edge
);

    logic vs_act;
    logic sync1;
    logic sync2;
    logic sync2_q;

    assign vs_act = (vs_in == VS_POL);

    always_ff @(posedge wfifo_wr_clk) begin
        if (!rstn) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_q <= 1'b0;
            vs_edge <= 1'b0;
        end else begin
            sync1   <= vs_act;
            sync2   <= sync1;
            sync2_q <= sync2;
            vs_edge <= sync2 & ~sync2_q;
        end
    end

endmodule

// File: rtl/wfifo_frame_packer.sv
// Packs pixels into FIFO words, flushes partial words at frame end and sequences
// the per-frame FIFO reset and guard window from the vsync edge.
module wfifo_frame_packer
    import wfifo_pkg::*;
#(
    parameter int              IN_W         = 32,
    parameter int              OUT_W        = 256,
    parameter bit              VS_POL       = 1'b1,
    parameter int              RST_CYCLES   = 14,
    parameter int              GUARD_CYCLES = 16,
    parameter logic [IN_W-1:0] PAD_VAL      = '0
) (
    input  logic             wfifo_wr_clk,
    input  logic             rstn,
    input  logic             vs_in,
    input  logic             pix_valid,
    input  logic [IN_W-1:0]  pix_data,
    input  logic             fifo_full,
    output logic             fifo_rst,
    output logic             fifo_wr_en,
    output logic [OUT_W-1:0] fifo_wr_data,
    output logic             frame_start,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      frame_words,
    output logic             overflow
);

    localparam int RATIO  = OUT_W / IN_W;
    localparam int LANE_W = cnt_w(RATIO);
    localparam int TMR_W  = cnt_w((RST_CYCLES > GUARD_CYCLES) ? RST_CYCLES : GUARD_CYCLES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [OUT_W-1:0]  PAD_WORD  = {RATIO{PAD_VAL}};

    fsm_state_t        state, next_state;
    logic [TMR_W-1:0]  timer;
    logic [LANE_W-1:0] lane, lane_nxt;
    logic [OUT_W-1:0]  word_buf, packed_word, wr_word;
    logic [15:0]       word_cnt, word_cnt_nxt;
    logic              vs_edge;
    logic              rst_done, guard_done, pix_take, word_done;
    logic              wr_try, wr_ok, latch_frame;

    vs_edge_sync #(.VS_POL(VS_POL)) u_vs_sync (
        .wfifo_wr_clk (wfifo_wr_clk),
        .rstn         (rstn),
        .vs_in        (vs_in),
        .vs_edge      (vs_edge)
    );

    always_ff @(posedge wfifo_wr_clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= next_state;
    end

    // The incoming pixel is packed before the frame-end decision, so lane_nxt drives it.
    always_comb begin
        rst_done   = (state == ST_RST)   && (timer == TMR_W'(RST_CYCLES - 1));
        guard_done = (state == ST_GUARD) && (timer == TMR_W'(GUARD_CYCLES - 1));
        pix_take   = (state == ST_RUN) && pix_valid;
        word_done  = pix_take && (lane == LAST_LANE);
        lane_nxt   = lane;
        if (pix_take) lane_nxt = word_done ? '0 : lane + LANE_W'(1);

        next_state = state;
        case (state)
            ST_IDLE:  if (vs_edge) next_state = ST_RST;
            ST_RST:   if (rst_done) next_state = ST_GUARD;
            ST_GUARD: if (guard_done) next_state = ST_RUN;
            ST_RUN:   if (vs_edge) next_state = (lane_nxt != '0) ? ST_FLUSH : ST_RST;
            ST_FLUSH: next_state = ST_RST;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        packed_word = word_buf;
        packed_word[int'(lane) * IN_W +: IN_W] = pix_data;
        wr_try       = word_done || (state == ST_FLUSH);
        wr_ok        = wr_try && !fifo_full;
        wr_word      = (state == ST_FLUSH) ? word_buf : packed_word;
        word_cnt_nxt = word_cnt;
        if (wr_ok && (word_cnt != 16'hFFFF)) word_cnt_nxt = word_cnt + 16'd1;
        latch_frame  = ((state == ST_RUN) || (state == ST_FLUSH)) && (next_state == ST_RST);
    end

    // NOTE: reset is synchronous, so the pad-filled word buffer is cleared by logic, not by an async flop pin.
    always_ff @(posedge wfifo_wr_clk) begin
        if (!rstn) begin
            timer        <= '0;
            lane         <= '0;
            word_buf     <= PAD_WORD;
            word_cnt     <= '0;
            fifo_rst     <= 1'b1;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            frame_start  <= 1'b0;
            frame_cnt    <= '0;
            frame_words  <= '0;
            overflow     <= 1'b0;
        end else begin
            if (next_state != state)
                timer <= '0;
            else if ((state == ST_RST) || (state == ST_GUARD))
                timer <= timer + TMR_W'(1);

            lane <= guard_done ? '0 : lane_nxt;

            // Unused lanes always hold PAD_VAL, so a flush can write the buffer as-is.
            if (wr_try || guard_done) word_buf <= PAD_WORD;
            else if (pix_take)        word_buf <= packed_word;

            word_cnt    <= guard_done ? 16'd0 : word_cnt_nxt;
            fifo_rst    <= (next_state == ST_RST);
            fifo_wr_en  <= wr_ok;
            if (wr_ok) fifo_wr_data <= wr_word;
            frame_start <= guard_done;
            if (guard_done)  frame_cnt   <= frame_cnt + 16'd1;
            if (latch_frame) frame_words <= word_cnt_nxt;
            if (wr_try && fifo_full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wfifo_frame_packer.sv
// Directed self-checking bench for wfifo_frame_packer at default parameters.
module tb_wfifo_frame_packer;

    logic         clk;
    logic         rstn;
    logic         vs_in;
    logic         pix_valid;
    logic [31:0]  pix_data;
    logic         fifo_full;
    logic         fifo_rst;
    logic         fifo_wr_en;
    logic [255:0] fifo_wr_data;
    logic         frame_start;
    logic [15:0]  frame_cnt;
    logic [15:0]  frame_words;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         valid;
        logic [31:0]  data;
        logic         full;
        logic         exp_wr;
        logic [255:0] exp_word;
    } vec_t;

    vec_t         tbl[25];
    logic [255:0] word0, word1, exp_w;
    logic [255:0] last_wr;
    int           lat, nrst, nguard, nwr;

    wfifo_frame_packer dut (
        .wfifo_wr_clk (clk),
        .rstn         (rstn),
        .vs_in        (vs_in),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .fifo_full    (fifo_full),
        .fifo_rst     (fifo_rst),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .frame_start  (frame_start),
        .frame_cnt    (frame_cnt),
        .frame_words  (frame_words),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Pulse vsync for one cycle, then run until fifo_rst rises; latency counts edges from vs_in high.
    task automatic end_frame(output int latency, output int writes);
        writes  = 0;
        vs_in   = 1'b1;
        step();
        vs_in   = 1'b0;
        latency = 1;
        for (int i = 0; i < 20; i++) begin
            if (fifo_wr_en) begin
                writes++;
                last_wr = fifo_wr_data;
            end
            if (fifo_rst) break;
            step();
            latency++;
        end
        check("rst_rise_timeout", fifo_rst, 1'b1);
    endtask

    // From the first fifo_rst cycle, run to frame_start; optionally re-pulse vsync mid-reset.
    task automatic wait_start(input int vs_at, output int rst_len, output int guard_len, output int writes);
        rst_len   = 0;
        guard_len = 0;
        writes    = 0;
        for (int i = 0; i < 80; i++) begin
            if (frame_start) break;
            if (fifo_rst) rst_len++;
            else          guard_len++;
            if (fifo_wr_en) writes++;
            vs_in = (vs_at > 0) && fifo_rst && (rst_len == vs_at);
            step();
        end
        vs_in = 1'b0;
        check("frame_start_timeout", frame_start, 1'b1);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pix_valid = tbl[i].valid;
            pix_data  = tbl[i].data;
            fifo_full = tbl[i].full;
            step();
            check($sformatf("vec%0d_wr_en", i), fifo_wr_en, tbl[i].exp_wr);
            if (tbl[i].exp_wr) check($sformatf("vec%0d_data", i), fifo_wr_data, tbl[i].exp_word);
        end
        pix_valid = 1'b0;
        fifo_full = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            word0[k*32 +: 32] = 32'(k);
            word1[k*32 +: 32] = 32'(k + 8);
        end
        // 0..15: two full words back to back; 16..24: 8th pixel hits a full FIFO.
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 32'(i), 1'b0, (i % 8) == 7, (i < 8) ? word0 : word1};
        for (int i = 16; i < 24; i++)
            tbl[i] = '{1'b1, 32'(200 + i), (i == 23), 1'b0, '0};
        tbl[24] = '{1'b0, 32'd0, 1'b1, 1'b0, '0};

        rstn = 1'b0; vs_in = 1'b0; pix_valid = 1'b0; pix_data = '0; fifo_full = 1'b0;
        repeat (4) step();
        check("rst_fifo_rst", fifo_rst, 1'b1);
        check("rst_wr_en", fifo_wr_en, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_words", frame_words, 16'd0);

        rstn = 1'b1;
        nrst = 0; nwr = 0;
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'b1;
            pix_data  = 32'(i);
            step();
            if (fifo_rst) nrst++;
            if (fifo_wr_en) nwr++;
        end
        pix_valid = 1'b0;
        check("idle_fifo_rst_cycles", 256'(nrst), 256'd0);
        check("idle_writes", 256'(nwr), 256'd0);

        // Frame 1: vsync timing
        end_frame(lat, nwr);
        check("vs_to_rst_latency", 256'(lat), 256'd4);
        wait_start(0, nrst, nguard, nwr);
        check("f1_rst_len", 256'(nrst), 256'd14);
        check("f1_guard_len", 256'(nguard), 256'd16);
        check("f1_frame_cnt", frame_cnt, 16'd1);
        run_vectors(0, 15);
        check("frame_start_one_cycle", frame_start, 1'b0);

        end_frame(lat, nwr);
        check("f1_end_writes", 256'(nwr), 256'd0);
        check("f1_frame_words", frame_words, 16'd2);
        wait_start(0, nrst, nguard, nwr);
        check("f2_frame_cnt", frame_cnt, 16'd2);

        // Frame 2: partial word flush
        exp_w = '0;
        for (int k = 0; k < 3; k++) begin
            pix_valid = 1'b1;
            pix_data  = 32'hA0C0_0000 + 32'(k);
            exp_w[k*32 +: 32] = pix_data;
            step();
        end
        pix_valid = 1'b0;
        end_frame(lat, nwr);
        check("flush_writes", 256'(nwr), 256'd1);
        check("flush_word", last_wr, exp_w);
        check("flush_frame_words", frame_words, 16'd1);
        wait_start(0, nrst, nguard, nwr);
        check("f3_frame_cnt", frame_cnt, 16'd3);

        // Frame 3: dropped word on fifo_full
        run_vectors(16, 24);
        check("ovf_set", overflow, 1'b1);
        end_frame(lat, nwr);
        check("ovf_frame_words", frame_words, 16'd0);
        wait_start(5, nrst, nguard, nwr);
        check("retrig_rst_len", 256'(nrst), 256'd14);
        check("retrig_guard_len", 256'(nguard), 256'd16);
        check("f4_frame_cnt", frame_cnt, 16'd4);
        check("ovf_sticky", overflow, 1'b1);

        // Frame 4: reset with 5 lanes filled
        for (int k = 0; k < 5; k++) begin
            pix_valid = 1'b1;
            pix_data  = 32'h5500_0000 + 32'(k);
            step();
        end
        rstn = 1'b0;
        step();
        check("midrst_wr_en", fifo_wr_en, 1'b0);
        check("midrst_fifo_rst", fifo_rst, 1'b1);
        check("midrst_overflow", overflow, 1'b0);
        check("midrst_frame_cnt", frame_cnt, 16'd0);
        step();
        check("midrst_wr_en_hold", fifo_wr_en, 1'b0);
        rstn = 1'b1;
        pix_valid = 1'b0;
        step();

        end_frame(lat, nwr);
        wait_start(0, nrst, nguard, nwr);
        check("post_rst_frame_cnt", frame_cnt, 16'd1);
        nwr = 0;
        for (int k = 0; k < 8; k++) begin
            pix_valid = 1'b1;
            pix_data  = 32'h7700_0000 + 32'(k);
            exp_w[k*32 +: 32] = pix_data;
            step();
            if (fifo_wr_en) nwr++;
        end
        pix_valid = 1'b0;
        check("post_rst_word_wr", 256'(nwr), 256'd1);
        check("post_rst_word", fifo_wr_data, exp_w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
